ppm_edge_detect: RTL and testbench



---
 rtl/ppm_edge_pkg.sv | 25 ++
 rtl/ppm_edge_chan.sv | 74 +++++++
 rtl/ppm_edge_detect.sv | 51 +++++
 tb/tb_ppm_edge_detect.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/ppm_edge_pkg.sv
// Shared types and parameter limits for the PPM edge detector.
// No datapath of its own; latency and backpressure are defined by the modules.
package ppm_edge_pkg;

  typedef enum logic [1:0] {
    EM_OFF  = 2'b00,
    EM_RISE = 2'b01,
    EM_FALL = 2'b10,
    EM_BOTH = 2'b11
  } edge_mode_t;

  localparam int N_CH_MIN   = 1;
  localparam int N_CH_MAX   = 16;
  localparam int SYNC_MIN   = 2;
  localparam int SYNC_MAX   = 4;
  localparam int FILT_W_MIN = 1;
  localparam int FILT_W_MAX = 8;

  // True when the mode reports an edge of the given polarity.
  function automatic logic mode_enables(input edge_mode_t mode, input logic rise);
    return rise ? (mode == EM_RISE || mode == EM_BOTH)
                : (mode == EM_FALL || mode == EM_BOTH);
  endfunction

endpackage

// File: rtl/ppm_edge_chan.sv
// One channel: synchroniser, stability filter, edge strobe, sticky pend/ovf.
// Edge accepted SYNC_STAGES+filt_len edges after first sample, strobe the cycle after; no backpressure.
module ppm_edge_chan
  import ppm_edge_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int FILT_W      = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              sig_in,
  input  logic [1:0]        edge_mode,
  input  logic [FILT_W-1:0] filt_len,
  input  logic              pend_clr,
  output logic              pulse_out,
  output logic              edge_rise,
  output logic              pend,
  output logic              ovf
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [FILT_W-1:0]      cnt;
  logic                   filt_q;
  logic                   s;
  logic                   mismatch;
  logic                   accept;
  logic                   en_edge;

  assign s        = sync_q[SYNC_STAGES-1];
  assign mismatch = s ^ filt_q;
  // >= rather than == so a counter left above a freshly lowered length still fires.
  assign accept   = mismatch && (cnt >= filt_len);
  assign en_edge  = accept && mode_enables(edge_mode_t'(edge_mode), s);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q    <= '0;
      cnt       <= '0;
      filt_q    <= 1'b0;
      pulse_out <= 1'b0;
      edge_rise <= 1'b0;
      pend      <= 1'b0;
      ovf       <= 1'b0;
    end else begin
      sync_q    <= {sync_q[SYNC_STAGES-2:0], sig_in};
      pulse_out <= en_edge;

      // The filter tracks the input in every mode, so enabling a channel later
      // never reports a stale level change.
      if (!mismatch) begin
        cnt <= '0;
      end else if (accept) begin
        filt_q    <= s;
        edge_rise <= s;
        cnt       <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end

      if (en_edge) begin
        pend <= 1'b1;
      end else if (pend_clr) begin
        pend <= 1'b0;
      end

      if (pend_clr) begin
        ovf <= 1'b0;
      end else if (en_edge && pend) begin
        ovf <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/ppm_edge_detect.sv
// Multi-channel glitch-filtered edge detector for the PPM decoder front end.
// Per-channel latency SYNC_STAGES+filt_len edges to accept, strobe one cycle later; no backpressure.
module ppm_edge_detect
  import ppm_edge_pkg::*;
#(
  parameter int N_CH        = 4,
  parameter int SYNC_STAGES = 2,
  parameter int FILT_W      = 3
) (
  input  logic [N_CH-1:0]   sig_in,
  input  logic              clk,
  input  logic              rst_n,
  input  logic [2*N_CH-1:0] edge_mode,
  input  logic [FILT_W-1:0] filt_len,
  input  logic [N_CH-1:0]   pend_clr,
  output logic [N_CH-1:0]   pulse_out,
  output logic [N_CH-1:0]   edge_rise,
  output logic [N_CH-1:0]   pend,
  output logic [N_CH-1:0]   ovf,
  output logic              any_pulse
);

  generate
    if (N_CH < N_CH_MIN || N_CH > N_CH_MAX ||
        SYNC_STAGES < SYNC_MIN || SYNC_STAGES > SYNC_MAX ||
        FILT_W < FILT_W_MIN || FILT_W > FILT_W_MAX) begin : g_bad_param
      $error("ppm_edge_detect: parameter out of range");
    end
  endgenerate

  for (genvar i = 0; i < N_CH; i++) begin : g_chan
    ppm_edge_chan #(
      .SYNC_STAGES (SYNC_STAGES),
      .FILT_W      (FILT_W)
    ) u_chan (
      .clk       (clk),
      .rst_n     (rst_n),
      .sig_in    (sig_in[i]),
      .edge_mode (edge_mode[2*i+1:2*i]),
      .filt_len  (filt_len),
      .pend_clr  (pend_clr[i]),
      .pulse_out (pulse_out[i]),
      .edge_rise (edge_rise[i]),
      .pend      (pend[i]),
      .ovf       (ovf[i])
    );
  end

  assign any_pulse = |pulse_out;

endmodule

// File: tb/tb_ppm_edge_detect.sv
// Directed bench for ppm_edge_detect: N_CH=4, SYNC_STAGES=2, FILT_W=3.
module tb_ppm_edge_detect;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] sig_in;
  logic [7:0] edge_mode;
  logic [2:0] filt_len;
  logic [3:0] pend_clr;
  logic [3:0] pulse_out;
  logic [3:0] edge_rise;
  logic [3:0] pend;
  logic [3:0] ovf;
  logic       any_pulse;

  int n_vec = 0;
  int n_err = 0;

  ppm_edge_detect #(
    .N_CH        (4),
    .SYNC_STAGES (2),
    .FILT_W      (3)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .sig_in    (sig_in),
    .edge_mode (edge_mode),
    .filt_len  (filt_len),
    .pend_clr  (pend_clr),
    .pulse_out (pulse_out),
    .edge_rise (edge_rise),
    .pend      (pend),
    .ovf       (ovf),
    .any_pulse (any_pulse)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Advance to 1 ns after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  int npulse;
  int t_rise;
  int t_fall;
  int bad_pol;
  logic er_at_rise;
  logic er_at_fall;

  initial begin
    rst_n     = 1'b0;
    sig_in    = 4'b0001;
    edge_mode = 8'b0000_0001;
    filt_len  = 3'd0;
    pend_clr  = 4'b0000;

    // Reset state and first edge after release
    repeat (3) tick();
    chk("rst_pulse", pulse_out, 4'h0);
    chk("rst_rise",  edge_rise, 4'h0);
    chk("rst_pend",  pend,      4'h0);
    chk("rst_ovf",   ovf,       4'h0);
    chk("rst_any",   any_pulse, 1'b0);
    rst_n = 1'b1;
    tick();
    chk("rel_e1_pulse", pulse_out, 4'h0);
    tick();
    chk("rel_e2_pulse", pulse_out, 4'h0);
    tick();
    chk("rel_e3_pulse", pulse_out, 4'h1);
    chk("rel_e3_any",   any_pulse, 1'b1);
    chk("rel_e3_rise",  edge_rise, 4'h1);
    chk("rel_e3_pend",  pend,      4'h1);
    tick();
    chk("rel_e4_pulse", pulse_out, 4'h0);
    pend_clr = 4'b0001;
    tick();
    pend_clr = 4'b0000;
    chk("clr0_pend", pend, 4'h0);

    // Filter L=3, both edges on channel 1: 3-cycle glitch is rejected
    edge_mode = 8'b0000_1100;
    filt_len  = 3'd3;
    sig_in[1] = 1'b1;
    npulse = 0;
    for (int i = 1; i <= 12; i++) begin
      tick();
      if (i == 3) sig_in[1] = 1'b0;
      if (pulse_out[1]) npulse++;
    end
    chk("glitch_pulses", npulse, 0);
    chk("glitch_pend",   pend[1], 1'b0);

    // 4-cycle high then low: rise accepted at tick 6, fall at tick 10
    sig_in[1] = 1'b1;
    npulse = 0; t_rise = -1; t_fall = -1;
    er_at_rise = 1'b0; er_at_fall = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      tick();
      if (i == 4) sig_in[1] = 1'b0;
      if (pulse_out[1]) begin
        npulse++;
        if (t_rise < 0) begin
          t_rise = i; er_at_rise = edge_rise[1];
        end else begin
          t_fall = i; er_at_fall = edge_rise[1];
        end
      end
    end
    chk("l3_pulses",  npulse, 2);
    chk("l3_rise_t",  t_rise, 6);
    chk("l3_rise_er", er_at_rise, 1'b1);
    chk("l3_fall_t",  t_fall, 10);
    chk("l3_fall_er", er_at_fall, 1'b0);
    chk("l3_pend",    pend[1], 1'b1);
    chk("l3_ovf",     ovf[1],  1'b1);

    // Clear coincident with an accepted edge while ovf is set
    sig_in[1] = 1'b1;
    for (int i = 1; i <= 6; i++) begin
      tick();
      if (i == 5) pend_clr = 4'b0010;
    end
    pend_clr = 4'b0000;
    chk("coin_pulse", pulse_out[1], 1'b1);
    chk("coin_pend",  pend[1],      1'b1);
    chk("coin_ovf",   ovf[1],       1'b0);
    pend_clr = 4'b0010;
    tick();
    pend_clr = 4'b0000;
    chk("clr1_pend", pend[1], 1'b0);
    chk("clr1_ovf",  ovf[1],  1'b0);

    // Falling-only mode on a period-20 square wave, L=0
    edge_mode = 8'b0010_0000;
    filt_len  = 3'd0;
    npulse = 0; bad_pol = 0;
    for (int t = 0; t < 60; t++) begin
      sig_in[2] = ((t / 10) % 2) == 0;
      tick();
      if (pulse_out[2]) begin
        npulse++;
        if (edge_rise[2]) bad_pol++;
      end
    end
    chk("fall_pulses",  npulse,  3);
    chk("fall_polarity", bad_pol, 0);
    chk("fall_pend",    pend[2], 1'b1);
    chk("fall_ovf",     ovf[2],  1'b1);

    // Mode off: filter keeps tracking but nothing is reported
    edge_mode = 8'b0000_0000;
    npulse = 0;
    for (int t = 60; t < 100; t++) begin
      sig_in[2] = ((t / 10) % 2) == 0;
      tick();
      if (any_pulse) npulse++;
    end
    sig_in[2] = 1'b0;
    chk("off_pulses", npulse,  0);
    chk("off_pend",   pend[2], 1'b1);
    chk("off_ovf",    ovf[2],  1'b1);
    repeat (4) tick();

    // Asynchronous reset mid-count with L=7, then full requalification
    edge_mode = 8'b0100_0000;
    filt_len  = 3'd7;
    sig_in[3] = 1'b1;
    repeat (5) tick();
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_pulse", pulse_out, 4'h0);
    chk("arst_rise",  edge_rise, 4'h0);
    chk("arst_pend",  pend,      4'h0);
    chk("arst_ovf",   ovf,       4'h0);
    chk("arst_any",   any_pulse, 1'b0);
    tick();
    tick();
    rst_n = 1'b1;
    npulse = 0; t_rise = -1;
    for (int i = 1; i <= 14; i++) begin
      tick();
      if (pulse_out[3]) begin
        npulse++;
        if (t_rise < 0) t_rise = i;
      end
    end
    chk("l7_pulses", npulse, 1);
    chk("l7_rise_t", t_rise, 10);
    chk("l7_pend",   pend,   4'h8);
    chk("l7_rise",   edge_rise[3], 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
